// File: rtl/decimal_entry_decoder.sv
// Keypad digit entry to 13-bit binary via 16-step reverse double-dabble; result 17 cycles after enter.
// Keys arriving while busy are dropped (no queue); optional ENTRY_AUTO_ENTER_EN starts conversion on the 4th digit.
module decimal_entry_decoder #(
  parameter int NUM_W = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic [15:0]      entry_bcd,
  output logic [2:0]       digit_count,
  output logic             busy,
  output logic [NUM_W-1:0] num,
  output logic             num_valid,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  localparam logic [15:0] MAX_VAL = 16'((1 << NUM_W) - 1);

  state_t      state;
  logic [31:0] w;
  logic [4:0]  step;
  logic [31:0] w_sh;
  logic [31:0] w_adj;
  logic [15:0] entry_shift;

  assign entry_shift = {entry_bcd[11:0], key_code};

  // One reverse double-dabble step: shift right, then pull each BCD nibble back below 8.
  always_comb begin
    w_sh  = w >> 1;
    w_adj = w_sh;
    for (int i = 0; i < 4; i++) begin
      if (w_sh[16 + 4*i +: 4] >= 4'd8)
        w_adj[16 + 4*i +: 4] = w_sh[16 + 4*i +: 4] - 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      w           <= '0;
      step        <= '0;
      entry_bcd   <= '0;
      digit_count <= '0;
      busy        <= 1'b0;
      num         <= '0;
      num_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      num_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            if (key_code <= 4'd9) begin
              if (digit_count < 3'd4) begin
                entry_bcd   <= entry_shift;
                digit_count <= digit_count + 3'd1;
`ifdef ENTRY_AUTO_ENTER_EN
                if (digit_count == 3'd3) begin
                  w     <= {entry_shift, 16'h0};
                  step  <= '0;
                  busy  <= 1'b1;
                  state <= CONVERT;
                end
`endif
              end
            end else begin
              case (key_code)
                4'hA: begin
                  entry_bcd   <= '0;
                  digit_count <= '0;
                end
                4'hB: begin
                  entry_bcd <= {4'h0, entry_bcd[15:4]};
                  if (digit_count != 3'd0)
                    digit_count <= digit_count - 3'd1;
                end
                4'hE: begin
                  w     <= {entry_bcd, 16'h0};
                  step  <= '0;
                  busy  <= 1'b1;
                  state <= CONVERT;
                end
                default: ;
              endcase
            end
          end
        end
        CONVERT: begin
          w    <= w_adj;
          step <= step + 5'd1;
          if (step == 5'd15)
            state <= DONE;
        end
        DONE: begin
          if (w[15:0] > MAX_VAL) begin
            num      <= '1;
            overflow <= 1'b1;
          end else begin
            num      <= w[NUM_W-1:0];
            overflow <= 1'b0;
          end
          num_valid   <= 1'b1;
          entry_bcd   <= '0;
          digit_count <= '0;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decimal_entry_decoder.sv
// Directed self-checking bench for decimal_entry_decoder; define ENTRY_AUTO_ENTER_EN to test auto-enter.
module tb_decimal_entry_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_count;
  logic        busy;
  logic [12:0] num;
  logic        num_valid;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  decimal_entry_decoder #(.NUM_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .entry_bcd(entry_bcd), .digit_count(digit_count), .busy(busy),
    .num(num), .num_valid(num_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Key is sampled by exactly one rising edge; returns at the negedge after it.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Counts negedges from just after the starting edge until num_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!num_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({entry_bcd, digit_count, busy, num, num_valid, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {entry_bcd, digit_count, busy, num, num_valid, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    checks++;
    if (entry_bcd !== 16'h1234 || digit_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_entry: got %h/%0d expected 1234/4", entry_bcd, digit_count);
    end
    press(4'hE);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_result(lat);
    checks++;
    if (lat != 17) begin errors++; $display("FAIL basic_latency: got %0d expected 17", lat); end
    checks++;
    if (num !== 13'd1234 || overflow !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: got num %0d ov %b busy %b expected 1234 0 0", num, overflow, busy);
    end
    checks++;
    if (entry_bcd !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL basic_cleared: got %h/%0d expected 0/0", entry_bcd, digit_count);
    end
    @(negedge clk);
    checks++;
    if (num_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse: got %b expected 0", num_valid); end
  endtask

  task automatic test_saturation;
    int lat;
    press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hE);
    wait_result(lat);
    checks++;
    if (lat != 17 || num !== 13'd8191 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL sat_9999: got lat %0d num %0d ov %b expected 17 8191 1", lat, num, overflow);
    end
    press(4'h8); press(4'h1); press(4'h9); press(4'h1); press(4'hE);
    wait_result(lat);
    checks++;
    if (lat != 17 || num !== 13'd8191 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL sat_8191: got lat %0d num %0d ov %b expected 17 8191 0", lat, num, overflow);
    end
  endtask

  task automatic test_edit;
    int lat;
    press(4'h5); press(4'h6); press(4'hB);
    checks++;
    if (entry_bcd !== 16'h0005 || digit_count !== 3'd1) begin
      errors++;
      $display("FAIL edit_backspace: got %h/%0d expected 0005/1", entry_bcd, digit_count);
    end
    press(4'h7); press(4'hE);
    wait_result(lat);
    checks++;
    if (num !== 13'd57 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL edit_57: got %0d ov %b expected 57 0", num, overflow);
    end
    press(4'h3); press(4'hA); press(4'h4); press(4'hE);
    wait_result(lat);
    checks++;
    if (num !== 13'd4) begin errors++; $display("FAIL edit_clear: got %0d expected 4", num); end
    press(4'hB); press(4'hF); press(4'hC);
    checks++;
    if (entry_bcd !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL edit_empty_keys: got %h/%0d expected 0/0", entry_bcd, digit_count);
    end
  endtask

  task automatic test_full_entry;
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    checks++;
    if (entry_bcd !== 16'h1234 || digit_count !== 3'd4 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_fifth_digit: got %h/%0d busy %b expected 1234/4 0", entry_bcd, digit_count, busy);
    end
    press(4'hA);
  endtask

  task automatic test_busy_drop;
    int pulses;
    press(4'h5); press(4'h0); press(4'hE);
    // now just after edge E; strobe 7 at E+1 and enter at E+2
    key_valid = 1'b1; key_code = 4'h7;
    @(negedge clk); key_code = 4'hE;
    @(negedge clk); key_valid = 1'b0;
    repeat (14) @(negedge clk);
    checks++;
    if (num_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL drop_pre_done: got nv %b busy %b expected 0 1", num_valid, busy);
    end
    key_valid = 1'b1; key_code = 4'h7; // sampled at E+17, state DONE
    @(negedge clk); key_valid = 1'b0;
    checks++;
    if (num_valid !== 1'b1 || num !== 13'd50) begin
      errors++;
      $display("FAIL drop_result: got nv %b num %0d expected 1 50", num_valid, num);
    end
    checks++;
    if (entry_bcd !== 16'h0 || digit_count !== 3'd0) begin
      errors++;
      $display("FAIL drop_entry: got %h/%0d expected 0/0", entry_bcd, digit_count);
    end
    pulses = 0;
    repeat (30) begin
      @(negedge clk);
      if (num_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_extra_pulse: got %0d busy %b expected 0 0", pulses, busy);
    end
  endtask

  task automatic test_zero;
    int lat;
    press(4'h6); press(4'h6); press(4'hE);
    wait_result(lat);
    press(4'hE);
    wait_result(lat);
    checks++;
    if (lat != 17 || num !== 13'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL zero_enter: got lat %0d num %0d ov %b expected 17 0 0", lat, num, overflow);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int pulses;
    press(4'h9); press(4'h1); press(4'hE);
    wait_result(lat);
    press(4'h1); press(4'h2); press(4'h3); press(4'hE);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({entry_bcd, digit_count, busy, num, num_valid, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", {entry_bcd, digit_count, busy, num, num_valid, overflow});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (num_valid) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_no_pulse: got %0d expected 0", pulses); end
    press(4'h4); press(4'h2); press(4'hE);
    wait_result(lat);
    checks++;
    if (lat != 17 || num !== 13'd42) begin
      errors++;
      $display("FAIL reset_recover: got lat %0d num %0d expected 17 42", lat, num);
    end
  endtask

`ifdef ENTRY_AUTO_ENTER_EN
  task automatic test_auto_enter;
    int lat;
    press(4'h2); press(4'h0); press(4'h2); press(4'h5);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL auto_busy: got %b expected 1", busy); end
    wait_result(lat);
    checks++;
    if (lat != 17 || num !== 13'd2025 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL auto_result: got lat %0d num %0d ov %b expected 17 2025 0", lat, num, overflow);
    end
  endtask
`endif

  initial begin
    test_reset;
`ifndef ENTRY_AUTO_ENTER_EN
    test_basic;
    test_saturation;
    test_full_entry;
`else
    test_auto_enter;
`endif
    test_edit;
    test_busy_drop;
    test_zero;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
